alu_op_issue: RTL
=================

Name: alu_op_issue

Overview:
- Sequential front end for the 32-bit RV32I ALU.
- Accepts raw instructions over a valid/ready handshake and decodes them into the ALU's 3-bit opcode and operand-source select, issuing through a second valid/ready handshake.
- For branches, consumes the ALU's zero/sign flags after issue and produces a one-cycle branch resolution.
- Sits between instruction fetch/decode and the ALU/branch unit.

Parameters:
- XLEN, 32, instruction width; fixed at 32 (RV32I).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction present on instr.
- in_ready  output  1  block can accept an instruction.
- instr  input  32  RV32I instruction word.
- out_valid  output  1  alu_opcode/alu_src_imm/is_branch are valid.
- out_ready  input  1  ALU stage accepts the issued operation.
- alu_opcode  output  3  000 ADD, 001 SLL, 010 SUB, 011 PASS_B, 100 XOR, 101 SRL, 110 OR, 111 AND.
- alu_src_imm  output  1  1 = ALU B operand is the immediate.
- is_branch  output  1  issued op is a conditional branch.
- flags_valid  input  1  zero_flag/sign_flag reflect the issued branch compare.
- zero_flag  input  1  ALU zero flag.
- sign_flag  input  1  ALU sign flag.
- branch_valid  output  1  one-cycle pulse; branch_taken is valid.
- branch_taken  output  1  branch outcome.
- illegal  output  1  one-cycle pulse; unsupported instruction dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=1; out_valid=0; alu_opcode=000; alu_src_imm=0; is_branch=0; branch_valid=0; branch_taken=0; illegal=0.
  - The internal funct3 latch clears to 000.
  - Reset mid-operation discards any held instruction or pending branch with no output pulse.
- State ISSUE_DECODE is not used. The states are IDLE, ISSUE, WAIT_FLAGS.
- IDLE:
  - in_ready=1.
  - On in_valid, the decode result is registered at the edge.
  - A legal instruction moves to ISSUE.
  - An illegal instruction produces illegal=1 for the next cycle only and stays in IDLE.
- ISSUE:
  - in_ready=0; out_valid=1; outputs are held stable until out_ready.
  - On out_ready: a branch moves to WAIT_FLAGS; otherwise the block moves to IDLE. out_valid drops the next cycle.
  - Minimum latency from in_valid to out_valid is 1 cycle.
- WAIT_FLAGS:
  - in_ready=0; out_valid=0.
  - On flags_valid, the flags are sampled. branch_valid=1 for exactly the next cycle with the registered branch_taken, and the block returns to IDLE.
  - flags_valid outside WAIT_FLAGS is ignored.
  - Condition by latched funct3: 000 BEQ taken=zero_flag; 001 BNE taken=!zero_flag; 100 BLT taken=sign_flag; 101 BGE taken=!sign_flag.
- Decode (op = instr[6:0], f3 = instr[14:12], f7b5 = instr[30]):
  - 0110011 (OP), alu_src_imm=0:
    - f3 000: ADD when f7b5=0, SUB when f7b5=1.
    - f3 001: SLL.
    - f3 100: XOR.
    - f3 101: SRL when f7b5=0; SRA (f7b5=1) is illegal.
    - f3 110: OR.
    - f3 111: AND.
    - f3 010 and 011 are illegal.
  - 0010011 (OP-IMM), alu_src_imm=1:
    - f3 000: ADD.
    - f3 001: SLL, only when f7b5=0.
    - f3 100: XOR.
    - f3 101: SRL, only when f7b5=0.
    - f3 110: OR.
    - f3 111: AND.
    - All else is illegal.
  - 0110111 (LUI): PASS_B, imm=1.
  - 0000011 (load) and 0100011 (store): ADD, imm=1.
  - 1100011 (branch): SUB, imm=0, is_branch=1. f3 must be in {000, 001, 100, 101}; otherwise illegal.
  - Any other op is illegal.
- Back-to-back: a new instruction is accepted in IDLE only, so peak throughput is 1 instruction per 2 cycles for non-branches.
- The in/out handshake may hold out_valid for any number of cycles. Outputs must not change while out_valid=1 and out_ready=0.

Test Plan:
- Reset check: assert rst_n=0 mid-ISSUE -> out_valid=0, in_ready=1, alu_opcode=000 immediately (no clock needed).
- Decode sweep: instr=0x40208033 (SUB) -> alu_opcode=010, alu_src_imm=0; instr=0x00A14093 (XORI) -> 100, imm=1; instr=0x123450B7 (LUI) -> 011, imm=1.
- Backpressure: issue ADD with out_ready=0 for 5 cycles -> out_valid and alu_opcode=000 held stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
- Branch resolution: instr=0x00208463 (BEQ) issued; flags_valid=1, zero_flag=1 after 3 wait cycles -> branch_valid pulse of 1 cycle, branch_taken=1. BGE (f3=101) with sign_flag=1 -> branch_taken=0.
- Illegal: instr=0x4020D0B3 (SRA) -> illegal pulses 1 cycle, out_valid stays 0, in_ready remains 1. instr=0x0000007F -> illegal.
- Reset during WAIT_FLAGS: BNE issued, rst_n pulsed before flags_valid -> no branch_valid; next instruction decodes normally.

Source files
------------

// File: rtl/alu_op_issue.sv
// alu_op_issue: sequential issue front end for the RV32I ALU.
// It decodes one instruction into an ALU opcode and operand select, then
// issues it over a valid/ready handshake. For a branch it waits for the
// ALU compare flags and reports the resolved outcome as a one-cycle pulse.
module alu_op_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      alu_opcode,
    output logic            alu_src_imm,
    output logic            is_branch,
    input  logic            flags_valid,
    input  logic            zero_flag,
    input  logic            sign_flag,
    output logic            branch_valid,
    output logic            branch_taken,
    output logic            illegal
);

    // Major opcodes accepted by this block.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU opcodes. For ADD/SLL/XOR/SRL/OR/AND the encoding equals the
    // RV32I funct3 of that operation, which the decoder relies on.
    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_PASS_B = 3'b011;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_FLAGS = 2'd2
    } state_t;

    state_t state, state_next;

    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5;

    logic       dec_legal;
    logic [2:0] dec_opcode;
    logic       dec_imm;
    logic       dec_branch;

    logic [2:0] funct3_q;
    logic       accept;
    logic       resolve;
    logic       cond_taken;

    assign op   = instr[6:0];
    assign f3   = instr[14:12];
    assign f7b5 = instr[30];

    // Handshake outputs are pure functions of state so reset takes effect
    // without waiting for a clock edge.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == ISSUE);

    assign accept  = in_ready && in_valid;
    assign resolve = (state == WAIT_FLAGS) && flags_valid;

    // Decode the presented instruction into ALU controls and a legality bit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        dec_legal  = 1'b0;
        dec_opcode = ALU_ADD;
        dec_imm    = 1'b0;
        dec_branch = 1'b0;
        case (op)
            OPC_OP: begin
                dec_opcode = f3;
                // funct3 010/011 (SLT/SLTU) and SRA have no ALU support.
                dec_legal  = (f3[2:1] != 2'b01) && !(f3 == 3'b101 && f7b5);
                if (f3 == 3'b000 && f7b5) begin
                    dec_opcode = ALU_SUB;
                end
            end
            OPC_OP_IMM: begin
                dec_opcode = f3;
                dec_imm    = 1'b1;
                // Shift-immediates need funct7[5]=0 (SRAI is unsupported).
                dec_legal  = (f3[2:1] != 2'b01) &&
                             !((f3[1:0] == 2'b01) && f7b5);
            end
            OPC_LUI: begin
                dec_opcode = ALU_PASS_B;
                dec_imm    = 1'b1;
                dec_legal  = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
                dec_opcode = ALU_ADD;
                dec_imm    = 1'b1;
                dec_legal  = 1'b1;
            end
            OPC_BRANCH: begin
                dec_opcode = ALU_SUB;
                dec_branch = 1'b1;
                // BEQ/BNE/BLT/BGE all have funct3[1]=0; BLTU/BGEU are out.
                dec_legal  = !f3[1];
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Branch condition from the funct3 latched at issue time.
    always_comb begin
        cond_taken = 1'b0;
        case (funct3_q)
            3'b000:  cond_taken = zero_flag;
            3'b001:  cond_taken = !zero_flag;
            3'b100:  cond_taken = sign_flag;
            3'b101:  cond_taken = !sign_flag;
            default: cond_taken = 1'b0;
        endcase
    end

    // Next-state logic for the IDLE -> ISSUE -> (WAIT_FLAGS) -> IDLE walk.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && dec_legal) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    state_next = is_branch ? WAIT_FLAGS : IDLE;
                end
            end
            WAIT_FLAGS: begin
                if (flags_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue registers: loaded only on a legal accept, so they stay stable
    // for the whole time out_valid is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode  <= ALU_ADD;
            alu_src_imm <= 1'b0;
            is_branch   <= 1'b0;
            funct3_q    <= 3'b000;
        end else if (accept && dec_legal) begin
            alu_opcode  <= dec_opcode;
            alu_src_imm <= dec_imm;
            is_branch   <= dec_branch;
            funct3_q    <= f3;
        end
    end

    // One-cycle pulses for branch resolution and dropped instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_valid <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            branch_valid <= resolve;
            illegal      <= accept && !dec_legal;
            if (resolve) begin
                branch_taken <= cond_taken;
            end
        end
    end

endmodule
